// File: rtl/instr_loader.sv
// instr_loader: write side of the 256 x 9-bit instruction memory.
// Takes a byte stream (count byte, then lo/hi byte pairs) over a
// valid/ready handshake and writes one 9-bit instruction per pair.
// Every output is a register, so the core sees clean levels while held.
module instr_loader #(
    parameter logic [7:0]  START_ADDR = 8'd0,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [8:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [8:0] loaded_count
);

    // Idle counter is sized to just reach TIMEOUT; it never counts past it.
    localparam int            TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LO,
        S_HI,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [TW-1:0] idle_cnt;
    logic [8:0]    remaining;   // instructions still to write; 256 fits in 9 bits
    logic [7:0]    lo_byte;
    logic          accept;

    // A byte moves only when the source offers it and we advertised ready.
    assign accept = in_valid && in_ready;

    // Loader FSM. Outputs are registered alongside the state, so every
    // transition also sets the decoded in_ready/busy levels of its target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= START_ADDR;
            mem_wdata    <= 9'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            loaded_count <= 9'd0;
            idle_cnt     <= '0;
            remaining    <= 9'd0;
            lo_byte      <= 8'd0;
        end else begin
            // Write strobe and done are single-cycle pulses.
            mem_we <= 1'b0;
            done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_COUNT;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        loaded_count <= 9'd0;
                        mem_addr     <= START_ADDR;
                        idle_cnt     <= '0;
                    end
                end

                S_COUNT, S_LO, S_HI: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (state == S_COUNT) begin
                            // A count byte of zero stands for a full 256-word load.
                            remaining <= {(in_data == 8'd0), in_data};
                            state     <= S_LO;
                        end else if (state == S_LO) begin
                            lo_byte <= in_data;
                            state   <= S_HI;
                        end else if (in_data[7:1] != 7'd0) begin
                            // Only bit 0 of the high byte is meaningful; anything
                            // else means the stream is corrupt, so abort unwritten.
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            mem_wdata <= {in_data[0], lo_byte};
                            mem_we    <= 1'b1;
                            state     <= S_WRITE;
                            in_ready  <= 1'b0;
                        end
                    end else if (idle_cnt == TMAX) begin
                        // Stream stalled too long: give up on this load.
                        state    <= S_ERR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end

                S_WRITE: begin
                    // mem_addr wraps naturally at 8 bits.
                    mem_addr     <= mem_addr + 8'd1;
                    loaded_count <= loaded_count + 9'd1;
                    remaining    <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_LO;
                        in_ready <= 1'b1;
                    end
                end

                S_DONE, S_ERR: begin
                    // start is deliberately not looked at here.
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    idle_cnt <= '0;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader with a behavioural
// model of the stream rules, a per-cycle output compare, and literal
// expectations for each scenario.
module tb_instr_loader;

    localparam logic [7:0] SA = 8'hFE;
    localparam int         TO = 8;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, mem_we, busy, done, error;
    logic [7:0] mem_addr;
    logic [8:0] mem_wdata, loaded_count;

    instr_loader #(.START_ADDR(SA), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_CNT, M_LO, M_HI, M_WR, M_DONE, M_ERR} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_idle = 0, m_left = 0, m_cnt = 0, m_addr = 0, m_wdata = 0, m_lo = 0;
    bit     m_we = 0, m_done = 0, m_err = 0;
    logic   m_acc;

    assign m_acc = in_valid && (m_mode == M_CNT || m_mode == M_LO || m_mode == M_HI);

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= M_IDLE; m_we <= 0; m_done <= 0; m_err <= 0;
            m_addr <= int'(SA); m_wdata <= 0; m_cnt <= 0; m_idle <= 0;
            m_left <= 0; m_lo <= 0;
        end else begin
            m_we   <= 0;
            m_done <= 0;
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode <= M_CNT; m_err <= 0; m_cnt <= 0; m_addr <= int'(SA);
                end
                M_CNT, M_LO, M_HI: begin
                    if (m_acc) begin
                        m_idle <= 0;
                        if (m_mode == M_CNT) begin
                            m_left <= (in_data == 0) ? 256 : int'(in_data);
                            m_mode <= M_LO;
                        end else if (m_mode == M_LO) begin
                            m_lo   <= int'(in_data);
                            m_mode <= M_HI;
                        end else if (int'(in_data) > 1) begin
                            m_mode <= M_ERR; m_err <= 1;
                        end else begin
                            m_wdata <= int'(in_data) * 256 + m_lo;
                            m_we    <= 1;
                            m_mode  <= M_WR;
                        end
                    end else if (m_idle >= TO) begin
                        m_mode <= M_ERR; m_err <= 1;
                    end else begin
                        m_idle <= m_idle + 1;
                    end
                end
                M_WR: begin
                    m_addr <= (m_addr + 1) % 256;
                    m_cnt  <= m_cnt + 1;
                    m_left <= m_left - 1;
                    m_mode <= (m_left == 1) ? M_DONE : M_LO;
                    m_done <= (m_left == 1);
                end
                default: begin
                    m_mode <= M_IDLE; m_idle <= 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [16:0] wlog[$];
    int          ndone = 0;

    always @(negedge clk) begin
        logic [31:0] act, exp;
        logic        e_rdy, e_busy;
        e_rdy  = (m_mode == M_CNT || m_mode == M_LO || m_mode == M_HI);
        e_busy = (m_mode != M_IDLE);
        act = {1'b0, in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, loaded_count};
        exp = {1'b0, e_rdy, m_we, 8'(m_addr), 9'(m_wdata), e_busy, m_done, m_err, 9'(m_cnt)};
        chk("cycle{rdy,we,addr,wdata,busy,done,err,cnt}", act, exp);
        if (mem_we) wlog.push_back({mem_addr, mem_wdata});
        if (done) ndone++;
    end

    // ---------------- stimulus helpers (start and end on a negedge) ----------------
    task automatic clear_log();
        wlog.delete();
        ndone = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_ready_wait actual=not_ready required=ready byte=%0h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_idle actual=busy required=idle");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] lo, hi;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_addr", mem_addr, 32'hFE);
        reset = 1'b0;
        @(negedge clk);

        // basic two-instruction load, back to back
        clear_log();
        do_start();
        send(8'h02, 0); send(8'h0F, 0); send(8'h01, 0); send(8'hAB, 0); send(8'h01, 0);
        wait_idle();
        chk("basic_nwrites", wlog.size(), 2);
        chk("basic_w0", wlog[0], {8'hFE, 9'h10F});
        chk("basic_w1", wlog[1], {8'hFF, 9'h1AB});
        chk("basic_count", loaded_count, 2);
        chk("basic_model_count", m_cnt, 2);
        chk("basic_err", error, 0);
        chk("basic_done", ndone, 1);

        // zero count = 256, address wrap, random bubbles
        clear_log();
        do_start();
        send(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            lo = 8'(i * 37 + 5);
            hi = {7'd0, i[0]};
            send(lo, $urandom_range(0, 3));
            send(hi, $urandom_range(0, 2));
        end
        wait_idle();
        chk("wrap_nwrites", wlog.size(), 256);
        for (int i = 0; i < 256 && i < wlog.size(); i++)
            chk("wrap_write", wlog[i], {8'(int'(SA) + i), i[0], 8'(i * 37 + 5)});
        chk("wrap_first_addr", wlog[0][16:9], 32'hFE);
        chk("wrap_third_addr", wlog[2][16:9], 32'h00);
        chk("wrap_last_addr", wlog[255][16:9], 32'hFD);
        chk("wrap_count", loaded_count, 256);
        chk("wrap_done", ndone, 1);

        // malformed high byte aborts after one good write
        clear_log();
        do_start();
        send(8'h03, 0); send(8'h11, 0); send(8'h00, 0); send(8'h22, 0); send(8'h04, 0);
        wait_idle();
        chk("bad_nwrites", wlog.size(), 1);
        chk("bad_w0", wlog[0], {8'hFE, 9'h011});
        chk("bad_err", error, 1);
        chk("bad_done", ndone, 0);
        repeat (5) @(negedge clk);
        chk("bad_err_sticky", error, 1);

        // timeout in LO, then recovery with acceptance on the timeout edge
        clear_log();
        do_start();
        chk("to_start_clears_err", error, 0);
        send(8'h01, 0);
        n = 0;
        while (!error && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 9);
        wait_idle();
        chk("to_err", error, 1);
        chk("to_nwrites", wlog.size(), 0);
        do_start();
        chk("rec_err_cleared", error, 0);
        send(8'h01, 0); send(8'h55, 8); send(8'h00, 0);
        wait_idle();
        chk("rec_nwrites", wlog.size(), 1);
        chk("rec_w0", wlog[0], {8'hFE, 9'h055});
        chk("rec_done", ndone, 1);
        chk("rec_err", error, 0);

        // reset during HI of the second instruction
        clear_log();
        do_start();
        send(8'h03, 0); send(8'h11, 0); send(8'h00, 0); send(8'h22, 0);
        in_valid = 1'b1; in_data = 8'h00; reset = 1'b1;
        @(negedge clk);
        chk("mrst_outs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, loaded_count},
            {1'b0, 1'b0, 8'hFE, 9'h000, 1'b0, 1'b0, 1'b0, 9'd0});
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_no_write", mem_we, 0);
        chk("mrst_nwrites", wlog.size(), 1);

        // start mid-load and during DONE is ignored
        clear_log();
        do_start();
        send(8'h02, 0); send(8'h33, 0);
        start = 1'b1;
        send(8'h01, 0);
        start = 1'b0;
        send(8'h44, 0); send(8'h00, 0);
        @(negedge clk);
        chk("ign_done_now", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_idle1", busy, 0);
        @(negedge clk);
        chk("ign_idle2", busy, 0);
        chk("ign_nwrites", wlog.size(), 2);
        chk("ign_w0", wlog[0], {8'hFE, 9'h133});
        chk("ign_w1", wlog[1], {8'hFF, 9'h044});
        chk("ign_count", loaded_count, 2);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program loader: the write side of the 256 x 9-bit instruction memory that the fetch path reads.
- Accepts a byte stream through a valid/ready handshake. The stream carries a count byte, then two bytes per instruction. The block assembles 9-bit instructions and drives the memory write port sequentially.
- Asserts busy for the whole load so the core can be held in reset. Reports completion with a one-cycle done pulse, and reports malformed or stalled streams with a sticky error flag.

Parameters:
- START_ADDR, 8'd0, first memory address written; addresses wrap modulo 256.
- TIMEOUT, 1023, maximum idle cycles allowed between accepted bytes while loading; exceeding it aborts the load.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  memory write enable.
- mem_addr  output  8  write address.
- mem_wdata  output  9  instruction to write.
- busy  output  1  a load is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a load completes successfully.
- error  output  1  sticky; set on abort, cleared by the next accepted start.
- loaded_count  output  9  instructions written in the current or most recent load.

Behaviour:
- Reset values (synchronous; reset applied mid-load has the same effect):
  - State goes to IDLE.
  - in_ready=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, busy=0, done=0, error=0, loaded_count=0, timeout counter=0.
  - No write is issued in the reset cycle or in the cycle after it.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready is 1 only in states COUNT, LO and HI, and is a registered state decode.
  - in_data is sampled only on acceptance.
- States:
  - IDLE: when start=1, clear error and loaded_count, set mem_addr=START_ADDR, go to COUNT. Otherwise start is ignored in every state other than IDLE.
  - COUNT: on acceptance, latch N=in_data, where 0 means 256. Go to LO.
  - LO: on acceptance, latch in_data as instruction bits [7:0]. Go to HI.
  - HI: on acceptance, in_data[0] becomes instruction bit 8.
    - If in_data[7:1] != 0, go to ERR; nothing is written.
    - Otherwise go to WRITE.
  - WRITE: exactly one cycle with mem_we=1, mem_addr=current address and mem_wdata=assembled instruction.
    - On the next edge: mem_addr increments (255 wraps to 0), loaded_count increments, and a remaining counter decrements.
    - Then go to DONE if this was instruction N, else to LO.
  - DONE: done=1 for this one cycle. Go to IDLE.
  - ERR: error is set for this one cycle. Go to IDLE. Words already written stay written.
- Latency and throughput:
  - The write occurs in the cycle after the HI byte is accepted.
  - Best-case throughput is one instruction per 3 cycles.
  - done asserts 1 cycle after the last WRITE cycle.
- Timeout:
  - In COUNT, LO and HI, the counter increments on every cycle with no acceptance and clears on acceptance.
  - When the counter equals TIMEOUT without acceptance, go to ERR on that edge.
  - The counter clears on entry to IDLE.
- Outputs outside WRITE:
  - mem_we=0 in every state except WRITE.
  - mem_wdata holds its last value.
- Simultaneous events:
  - A byte accepted on the same edge the timeout would fire counts as acceptance; no error.
  - start asserted during DONE or ERR is ignored.
- busy is 1 from the cycle after start is accepted through the DONE or ERR cycle inclusive.

Test Plan:
- Basic load of two instructions:
  - Stimulus: start, then bytes 0x02, 0x0F, 0x01, 0xAB, 0x01 with in_valid held high.
  - Response: writes 0x10F at address 0, then 0x1AB at address 1. One done pulse. loaded_count=2, error=0.
- Zero count means 256 with address wrap:
  - Stimulus: START_ADDR=8'hFE, count byte 0x00, 256 instruction pairs.
  - Response: 256 writes, at addresses FE, FF, 00 … FD. loaded_count=256, then done.
- Malformed high byte:
  - Stimulus: count 0x03. Pair 0x11/0x00 is valid; next pair is 0x22/0x04.
  - Response: exactly one write (0x011 at address 0). error=1 and stays 1. No done pulse. Returns to IDLE.
- Timeout, then recovery:
  - Stimulus: TIMEOUT=8. Start, count 0x01, then in_valid held low.
  - Response: error asserts after 8 idle cycles in LO.
  - A subsequent start clears error, and a load of 0x01, 0x55, 0x00 writes 0x055 and pulses done.
- Backpressure and bubbles:
  - Stimulus: in_valid randomly deasserted during the stream. A byte is held on in_data while in_ready=0 during WRITE.
  - Response: no byte is lost or duplicated, and the written data matches the stream.
- Reset and start ignoring:
  - Stimulus: reset asserted for 1 cycle during HI of the second instruction.
  - Response: all outputs take their reset values, and no write follows.
  - Separately, start pulsed mid-load is ignored and the load completes normally.
